shield_arbiter: RTL and testbench



---
 rtl/shield_pkg.sv | 22 ++
 rtl/shield_rr_pick.sv | 37 +++
 rtl/shield_arbiter.sv | 136 +++++++++++++
 tb/tb_shield_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shield_pkg.sv
// Shared types and helpers for the shield datapath ownership arbiter.
// Holds the FSM state type, the idle select code and one-hot to select mapping.
package shield_pkg;

    typedef enum logic {
        IDLE,
        OWN
    } arb_state_e;

    localparam int unsigned SEL_IDLE = 0;

    // One-hot owner vector (up to 15 channels) to select code k+1.
    function automatic logic [3:0] onehot_to_sel(input logic [14:0] oh);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 15; i++) begin
            if (oh[i]) s = s | 4'(i + 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/shield_rr_pick.sv
// Combinational picker: fixed-priority or round-robin selection.
// Ports: req_i requests, base_i last granted index, rr_i mode, pick_o one-hot, valid_o.
module shield_rr_pick #(
    parameter int NUM_CH = 3,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  base_i,
    input  logic              rr_i,
    output logic [NUM_CH-1:0] pick_o,
    output logic              valid_o
);

    int base;
    int best;
    int d;

    // Distance from the base is measured circularly; fixed mode uses a base
    // of NUM_CH-1 so the search starts at channel 0.
    always_comb begin
        pick_o  = '0;
        valid_o = |req_i;
        base    = rr_i ? int'(base_i) : NUM_CH - 1;
        best    = NUM_CH;
        d       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            d = i - base - 1;
            if (d < 0) d = d + NUM_CH;
            if (req_i[i] && d < best) begin
                best      = d;
                pick_o    = '0;
                pick_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shield_arbiter.sv
// Ownership arbiter for the shield's shared output mux with watchdog release.
// Ports: start_i/done_i per channel, timeout_lim_i; choose, grant_o, busy_o,
// pending_o, timeout_o, timeout_ch_o (all registered).
module shield_arbiter
    import shield_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int SEL_W   = $clog2(NUM_CH + 1),
    parameter int TO_W    = 16,
    parameter int RR_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] start_i,
    input  logic [NUM_CH-1:0] done_i,
    input  logic [TO_W-1:0]   timeout_lim_i,
    output logic [SEL_W-1:0]  choose,
    output logic [NUM_CH-1:0] grant_o,
    output logic              busy_o,
    output logic [NUM_CH-1:0] pending_o,
    output logic              timeout_o,
    output logic [SEL_W-1:0]  timeout_ch_o
);

    localparam int   PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic RR    = (RR_MODE != 0) && (NUM_CH > 1);

    arb_state_e        state_q, state_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]  choose_q, choose_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              to_q, to_d;
    logic [SEL_W-1:0]  to_ch_q, to_ch_d;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] own_mask;
    logic [NUM_CH-1:0] pick;
    logic [SEL_W-1:0]  pick_sel;
    logic              valid;
    logic              rel_done;
    logic              to_hit;
    logic              rel;

    assign rel_done = |(done_i & grant_q);
    assign to_hit   = (state_q == OWN) && (timeout_lim_i != '0)
                   && (cnt_q == timeout_lim_i - TO_W'(1));
    assign rel      = (state_q == OWN) && (rel_done || to_hit);

    // A start from the owner only counts when it is being released,
    // which re-queues it behind the normal pick.
    assign own_mask = rel ? '0 : grant_q;
    assign req      = (pend_q & ~done_i) | (start_i & ~own_mask);
    assign pick_sel = SEL_W'(onehot_to_sel(15'(pick)));

    shield_rr_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req_i   (req),
        .base_i  (ptr_q),
        .rr_i    (RR),
        .pick_o  (pick),
        .valid_o (valid)
    );

    always_comb begin
        state_d  = state_q;
        pend_d   = req;
        grant_d  = grant_q;
        choose_d = choose_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        to_d     = 1'b0;
        to_ch_d  = to_ch_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            OWN: begin
                if (rel) begin
                    if (to_hit && !rel_done) begin
                        to_d    = 1'b1;
                        to_ch_d = choose_q;
                    end
                    state_d  = IDLE;
                    grant_d  = '0;
                    choose_d = SEL_W'(SEL_IDLE);
                    cnt_d    = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_q == IDLE || rel) && valid) begin
            state_d  = OWN;
            pend_d   = req & ~pick;
            grant_d  = pick;
            choose_d = pick_sel;
            cnt_d    = '0;
            ptr_d    = PTR_W'(pick_sel - SEL_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            grant_q  <= '0;
            choose_q <= '0;
            cnt_q    <= '0;
            ptr_q    <= PTR_W'(NUM_CH - 1);
            to_q     <= 1'b0;
            to_ch_q  <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            grant_q  <= grant_d;
            choose_q <= choose_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            to_q     <= to_d;
            to_ch_q  <= to_ch_d;
        end
    end

    assign choose       = choose_q;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == OWN);
    assign pending_o    = pend_q;
    assign timeout_o    = to_q;
    assign timeout_ch_o = to_ch_q;

endmodule

// File: tb/tb_shield_arbiter.sv
// Testbench for shield_arbiter: directed scenarios plus randomized traffic
// against a behavioural model, on a 3-ch fixed and a 4-ch round-robin instance.
module tb_shield_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [2:0]  st_f = '0, dn_f = '0;
    logic [15:0] lim_f = '0;
    logic [1:0]  choose_f, toch_f;
    logic [2:0]  grant_f, pend_f;
    logic        busy_f, to_f;

    logic [3:0]  st_r = '0, dn_r = '0;
    logic [15:0] lim_r = '0;
    logic [2:0]  choose_r, toch_r;
    logic [3:0]  grant_r, pend_r;
    logic        busy_r, to_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shield_arbiter #(.NUM_CH(3), .TO_W(16), .RR_MODE(0)) u_fix (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (st_f),
        .done_i        (dn_f),
        .timeout_lim_i (lim_f),
        .choose        (choose_f),
        .grant_o       (grant_f),
        .busy_o        (busy_f),
        .pending_o     (pend_f),
        .timeout_o     (to_f),
        .timeout_ch_o  (toch_f)
    );

    shield_arbiter #(.NUM_CH(4), .TO_W(16), .RR_MODE(1)) u_rr (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (st_r),
        .done_i        (dn_r),
        .timeout_lim_i (lim_r),
        .choose        (choose_r),
        .grant_o       (grant_r),
        .busy_o        (busy_r),
        .pending_o     (pend_r),
        .timeout_o     (to_r),
        .timeout_ch_o  (toch_r)
    );

    // Behavioural model: index 0 = fixed 3-ch, index 1 = round-robin 4-ch.
    int          m_n[2]  = '{3, 4};
    bit          m_rr[2] = '{1'b0, 1'b1};
    int          m_owner[2];
    bit [15:0]   m_pend[2];
    int          m_cnt[2];
    int          m_ptr[2];
    bit          m_to[2];
    int          m_toch[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_pend[d]  = '0;
            m_cnt[d]   = 0;
            m_ptr[d]   = m_n[d] - 1;
            m_to[d]    = 1'b0;
            m_toch[d]  = 0;
        end
    endtask

    task automatic model_step(input int d, input bit [15:0] st,
                              input bit [15:0] dn, input int lim);
        int  n;
        int  own;
        bit  by_done;
        bit  rel;
        int  pk;
        int  c;
        n       = m_n[d];
        own     = m_owner[d];
        by_done = (own >= 0) && dn[own];
        rel     = (own >= 0) && (by_done || (lim != 0 && m_cnt[d] == lim - 1));
        m_to[d] = rel && !by_done;
        if (m_to[d]) m_toch[d] = own + 1;
        for (int k = 0; k < n; k++) begin
            if (k == own) begin
                if (rel && st[k]) m_pend[d][k] = 1'b1;
            end else if (st[k]) begin
                m_pend[d][k] = 1'b1;
            end else if (dn[k]) begin
                m_pend[d][k] = 1'b0;
            end
        end
        if (own < 0 || rel) begin
            pk = -1;
            for (int j = 1; j <= n; j++) begin
                c = m_rr[d] ? (m_ptr[d] + j) % n : j - 1;
                if (pk < 0 && m_pend[d][c]) pk = c;
            end
            m_cnt[d] = 0;
            if (pk >= 0) begin
                m_owner[d]    = pk;
                m_pend[d][pk] = 1'b0;
                m_ptr[d]      = pk;
            end else begin
                m_owner[d] = -1;
            end
        end else if (m_cnt[d] < 65535) begin
            m_cnt[d] = m_cnt[d] + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        st_f = '0; dn_f = '0; st_r = '0; dn_r = '0;
        lim_f = '0; lim_r = '0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({choose_f, grant_f, busy_f, pend_f, to_f, toch_f} !== '0) begin
            errors++;
            $display("FAIL reset_fix: got %b required 0",
                     {choose_f, grant_f, busy_f, pend_f, to_f, toch_f});
        end
        checks++;
        if ({choose_r, grant_r, busy_r, pend_r, to_r, toch_r} !== '0) begin
            errors++;
            $display("FAIL reset_rr: got %b required 0",
                     {choose_r, grant_r, busy_r, pend_r, to_r, toch_r});
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
    endtask

    task automatic test_fixed();
        st_f = 3'b110;
        step();
        st_f = '0;
        checks++;
        if (choose_f !== 2'd2 || grant_f !== 3'b010 || pend_f !== 3'b100
            || busy_f !== 1'b1) begin
            errors++;
            $display("FAIL fixed_grant: choose %0d grant %b pend %b required 2 010 100",
                     choose_f, grant_f, pend_f);
        end
        dn_f = 3'b010;
        step();
        dn_f = '0;
        checks++;
        if (choose_f !== 2'd3 || grant_f !== 3'b100 || busy_f !== 1'b1) begin
            errors++;
            $display("FAIL fixed_handoff: choose %0d grant %b required 3 100",
                     choose_f, grant_f);
        end
        dn_f = 3'b100;
        step();
        dn_f = '0;
        checks++;
        if (choose_f !== 2'd0 || busy_f !== 1'b0 || grant_f !== 3'b000) begin
            errors++;
            $display("FAIL fixed_idle: choose %0d busy %b required 0 0",
                     choose_f, busy_f);
        end
    endtask

    task automatic test_round_robin();
        int exp_sel[4] = '{2, 3, 4, 1};
        st_r = 4'b1111;
        step();
        st_r = '0;
        checks++;
        if (choose_r !== 3'd1 || pend_r !== 4'b1110) begin
            errors++;
            $display("FAIL rr_first: choose %0d pend %b required 1 1110",
                     choose_r, pend_r);
        end
        for (int i = 0; i < 4; i++) begin
            st_r = grant_r;
            dn_r = grant_r;
            step();
            st_r = '0;
            dn_r = '0;
            checks++;
            if (choose_r !== 3'(exp_sel[i]) || busy_r !== 1'b1) begin
                errors++;
                $display("FAIL rr_order%0d: choose %0d required %0d",
                         i, choose_r, exp_sel[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            dn_r = grant_r;
            step();
            dn_r = '0;
        end
        checks++;
        if (busy_r !== 1'b0 || choose_r !== 3'd0 || pend_r !== 4'b0) begin
            errors++;
            $display("FAIL rr_drain: busy %b choose %0d pend %b required 0 0 0",
                     busy_r, choose_r, pend_r);
        end
    endtask

    task automatic test_watchdog();
        lim_f = 16'd5;
        st_f  = 3'b010;
        step();
        st_f = '0;
        checks++;
        if (choose_f !== 2'd2) begin
            errors++;
            $display("FAIL wd_grant: choose %0d required 2", choose_f);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (to_f !== 1'b0 || busy_f !== 1'b1) begin
                errors++;
                $display("FAIL wd_early%0d: timeout %b busy %b required 0 1",
                         i, to_f, busy_f);
            end
        end
        step();
        checks++;
        if (to_f !== 1'b1 || toch_f !== 2'd2 || busy_f !== 1'b0
            || choose_f !== 2'd0) begin
            errors++;
            $display("FAIL wd_fire: timeout %b ch %0d busy %b required 1 2 0",
                     to_f, toch_f, busy_f);
        end
        step();
        checks++;
        if (to_f !== 1'b0 || toch_f !== 2'd2) begin
            errors++;
            $display("FAIL wd_pulse: timeout %b ch %0d required 0 2",
                     to_f, toch_f);
        end
        lim_f = '0;
    endtask

    task automatic test_abort();
        st_f = 3'b101;
        step();
        st_f = '0;
        checks++;
        if (choose_f !== 2'd1 || pend_f !== 3'b100) begin
            errors++;
            $display("FAIL abort_setup: choose %0d pend %b required 1 100",
                     choose_f, pend_f);
        end
        dn_f = 3'b100;
        step();
        dn_f = '0;
        checks++;
        if (pend_f !== 3'b000 || choose_f !== 2'd1) begin
            errors++;
            $display("FAIL abort_clear: pend %b choose %0d required 000 1",
                     pend_f, choose_f);
        end
        dn_f = 3'b001;
        step();
        dn_f = '0;
        checks++;
        if (choose_f !== 2'd0 || busy_f !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: choose %0d required 0", choose_f);
        end
    endtask

    task automatic test_owner_restart();
        lim_f = 16'd4;
        st_f  = 3'b001;
        step();
        st_f = '0;
        step();
        step();
        st_f = 3'b001;
        dn_f = 3'b001;
        step();
        st_f = '0;
        dn_f = '0;
        checks++;
        if (choose_f !== 2'd1 || pend_f !== 3'b000 || busy_f !== 1'b1) begin
            errors++;
            $display("FAIL restart_grant: choose %0d pend %b required 1 000",
                     choose_f, pend_f);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (to_f !== 1'b0 || busy_f !== 1'b1) begin
                errors++;
                $display("FAIL restart_wd%0d: timeout %b busy %b required 0 1",
                         i, to_f, busy_f);
            end
        end
        step();
        checks++;
        if (to_f !== 1'b1 || toch_f !== 2'd1) begin
            errors++;
            $display("FAIL restart_fire: timeout %b ch %0d required 1 1",
                     to_f, toch_f);
        end
        lim_f = '0;
        step();
    endtask

    task automatic test_async_reset();
        st_f = 3'b111;
        step();
        st_f = '0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({choose_f, grant_f, busy_f, pend_f, to_f, toch_f} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b required 0",
                     {choose_f, grant_f, busy_f, pend_f, to_f, toch_f});
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (choose_f !== 2'd0 || busy_f !== 1'b0 || to_f !== 1'b0) begin
            errors++;
            $display("FAIL async_after: choose %0d busy %b required 0 0",
                     choose_f, busy_f);
        end
    endtask

    task automatic test_random();
        int eo;
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            if (m_owner[0] < 0 && $urandom_range(0, 3) == 0)
                lim_f = 16'($urandom_range(0, 6));
            if (m_owner[1] < 0 && $urandom_range(0, 3) == 0)
                lim_r = 16'($urandom_range(0, 6));
            st_f = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b0;
            dn_f = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
            st_r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            dn_r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            if (m_owner[0] >= 0 && $urandom_range(0, 3) == 0)
                dn_f[m_owner[0]] = 1'b1;
            if (m_owner[1] >= 0 && $urandom_range(0, 3) == 0)
                dn_r[m_owner[1]] = 1'b1;
            @(posedge clk);
            model_step(0, 16'(st_f), 16'(dn_f), int'(lim_f));
            model_step(1, 16'(st_r), 16'(dn_r), int'(lim_r));
            #1;
            eo = m_owner[0];
            checks++;
            if (choose_f !== 2'(eo + 1) || busy_f !== (eo >= 0)
                || grant_f !== ((eo >= 0) ? 3'(1 << eo) : 3'b0)) begin
                errors++;
                $display("FAIL rnd_fix_own c%0d: choose %0d grant %b required owner %0d",
                         c, choose_f, grant_f, eo);
            end
            checks++;
            if (pend_f !== m_pend[0][2:0]) begin
                errors++;
                $display("FAIL rnd_fix_pend c%0d: got %b required %b",
                         c, pend_f, m_pend[0][2:0]);
            end
            checks++;
            if (to_f !== m_to[0] || toch_f !== 2'(m_toch[0])) begin
                errors++;
                $display("FAIL rnd_fix_to c%0d: got %b/%0d required %b/%0d",
                         c, to_f, toch_f, m_to[0], m_toch[0]);
            end
            eo = m_owner[1];
            checks++;
            if (choose_r !== 3'(eo + 1) || busy_r !== (eo >= 0)
                || grant_r !== ((eo >= 0) ? 4'(1 << eo) : 4'b0)) begin
                errors++;
                $display("FAIL rnd_rr_own c%0d: choose %0d grant %b required owner %0d",
                         c, choose_r, grant_r, eo);
            end
            checks++;
            if (pend_r !== m_pend[1][3:0]) begin
                errors++;
                $display("FAIL rnd_rr_pend c%0d: got %b required %b",
                         c, pend_r, m_pend[1][3:0]);
            end
            checks++;
            if (to_r !== m_to[1] || toch_r !== 3'(m_toch[1])) begin
                errors++;
                $display("FAIL rnd_rr_to c%0d: got %b/%0d required %b/%0d",
                         c, to_r, toch_r, m_to[1], m_toch[1]);
            end
        end
        st_f = '0; dn_f = '0; st_r = '0; dn_r = '0;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_watchdog();
        test_abort();
        test_owner_restart();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
